// File: rtl/nice_merger.sv
// N-to-1 packet merger with packet-granular round-robin arbitration.
// Output beat is registered and tagged with its source port index.
module nice_merger #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 32,
  localparam int SRC_W    = $clog2(NUM_PORTS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_PORTS-1:0]        in_valid,
  output logic [NUM_PORTS-1:0]        in_ready,
  input  logic [NUM_PORTS*DATA_W-1:0] in_data,
  input  logic [NUM_PORTS-1:0]        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic                        out_last,
  output logic [SRC_W-1:0]            out_src
);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_e;

  localparam logic [SRC_W:0] NP =
    (SRC_W+1)'(NUM_PORTS);

  state_e               state_q;
  logic [SRC_W-1:0]     rr_ptr_q;
  logic [SRC_W-1:0]     lock_src_q;
  logic                 valid_q;
  logic [DATA_W-1:0]    data_q;
  logic                 last_q;
  logic [SRC_W-1:0]     src_q;

  logic [NUM_PORTS-1:0] grant;
  logic [SRC_W-1:0]     gnt_idx;
  logic                 gnt_found;
  logic [SRC_W:0]       scan;
  logic [SRC_W:0]       inc_w;
  logic [SRC_W-1:0]     rr_d;
  logic                 can_load;
  logic                 xfer;
  logic [DATA_W-1:0]    sel_data;
  logic                 sel_last;

  assign can_load = !valid_q || out_ready;
  assign in_ready = grant & {NUM_PORTS{can_load}};
  assign xfer     = |(in_valid & in_ready);
  assign sel_data = in_data[gnt_idx*DATA_W +: DATA_W];
  assign sel_last = in_last[gnt_idx];

  // Pointer to the port after the winner, wrapping at NUM_PORTS.
  assign inc_w = {1'b0, gnt_idx} + 1'b1;
  assign rr_d  = (inc_w == NP) ? '0 : inc_w[SRC_W-1:0];

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_last  = last_q;
  assign out_src   = src_q;

  // Grant: owner while locked, else first valid port from rr_ptr.
  always_comb begin
    grant     = '0;
    gnt_idx   = '0;
    gnt_found = 1'b0;
    scan      = {1'b0, rr_ptr_q};
    if (state_q == LOCKED) begin
      grant[lock_src_q] = 1'b1;
      gnt_idx           = lock_src_q;
    end else begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        if (!gnt_found && in_valid[scan[SRC_W-1:0]]) begin
          gnt_found               = 1'b1;
          grant[scan[SRC_W-1:0]] = 1'b1;
          gnt_idx                 = scan[SRC_W-1:0];
        end
        scan = scan + 1'b1;
        if (scan == NP) scan = '0;
      end
    end
  end

  // Packet FSM, round-robin pointer and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      lock_src_q <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      last_q     <= 1'b0;
      src_q      <= '0;
    end else begin
      if (xfer) begin
        valid_q <= 1'b1;
        data_q  <= sel_data;
        last_q  <= sel_last;
        src_q   <= gnt_idx;
        unique case (state_q)
          IDLE: begin
            if (sel_last) begin
              rr_ptr_q <= rr_d;
            end else begin
              state_q    <= LOCKED;
              lock_src_q <= gnt_idx;
            end
          end
          LOCKED: begin
            if (sel_last) begin
              state_q  <= IDLE;
              rr_ptr_q <= rr_d;
            end
          end
          default: state_q <= IDLE;
        endcase
      end else if (out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_nice_merger.sv
// Testbench for nice_merger: directed scenarios plus randomized
// streams checked against a packet-level round-robin model.
module tb_nice_merger;

  localparam int N  = 4;
  localparam int DW = 32;

  typedef struct packed {
    logic [1:0]    src;
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_last;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic            out_last;
  logic [1:0]      out_src;

  logic [2:0]      v3;
  logic [2:0]      r3;
  logic [3*DW-1:0] d3;
  logic [2:0]      l3;
  logic            ov3;
  logic            or3;
  logic [DW-1:0]   od3;
  logic            ol3;
  logic [1:0]      os3;

  int checks = 0;
  int errors = 0;

  logic [DW:0] pq [N][$];
  logic [DW:0] cp [N][$];
  beat_t       expq[$];

  nice_merger #(.NUM_PORTS(N), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last),
    .out_src(out_src)
  );

  nice_merger #(.NUM_PORTS(3), .DATA_W(DW)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v3), .in_ready(r3),
    .in_data(d3), .in_last(l3),
    .out_valid(ov3), .out_ready(or3),
    .out_data(od3), .out_last(ol3),
    .out_src(os3)
  );

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    in_last   = '0;
    out_ready = 1'b0;
    v3  = '0;
    d3  = '0;
    l3  = '0;
    or3 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 ||
        out_last !== 1'b0 || out_src !== 2'd0) begin
      errors++;
      $display("FAIL reset_out: got v=%b d=%h l=%b s=%0d want 0 0 0 0",
               out_valid, out_data, out_last, out_src);
    end
    checks++;
    if (in_ready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_noreq: in_ready=%b want 0000", in_ready);
    end
    in_valid = 4'b0010;
    #1;
    checks++;
    if (in_ready !== 4'b0010) begin
      errors++;
      $display("FAIL reset_grant: in_ready=%b want 0010", in_ready);
    end
    in_valid = '0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_source();
    logic [DW-1:0] vals [3];
    vals[0] = 32'hA;
    vals[1] = 32'hB;
    vals[2] = 32'hC;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 4'b0100;
      in_data[2*DW +: DW] = vals[i];
      in_last[2] = (i == 2);
      @(negedge clk);
      checks++;
      if (in_ready !== 4'b0100) begin
        errors++;
        $display("FAIL single_ready%0d: in_ready=%b want 0100",
                 i, in_ready);
      end
      checks++;
      if (i == 0) begin
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL single_lat: out_valid=%b want 0", out_valid);
        end
      end else if (out_valid !== 1'b1 || out_data !== vals[i-1] ||
                   out_src !== 2'd2 || out_last !== 1'b0) begin
        errors++;
        $display("FAIL single_beat%0d: v=%b d=%h s=%0d l=%b want 1 %h 2 0",
                 i-1, out_valid, out_data, out_src, out_last, vals[i-1]);
      end
      @(posedge clk);
      #1;
    end
    in_valid = '0;
    in_last  = '0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hC ||
        out_src !== 2'd2 || out_last !== 1'b1) begin
      errors++;
      $display("FAIL single_beat2: v=%b d=%h s=%0d l=%b want 1 c 2 1",
               out_valid, out_data, out_src, out_last);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_drain: out_valid=%b want 0", out_valid);
    end
    @(posedge clk);
    #1;
  endtask

  // Randomized (mode 0) or all-single-beat (mode 1) backlogged stream.
  task automatic run_stream(input int mode, input int ready_pct,
                            input bit no_bubble, input string tag);
    int   rr, found, got, total, cycles, bubbles, npk, len;
    bit   started, done;
    logic [DW:0] b;
    logic [N-1:0] hs;
    beat_t e;
    do_reset();
    for (int p = 0; p < N; p++) begin
      pq[p].delete();
      npk = (mode == 1) ? 3 : $urandom_range(0, 3);
      for (int k = 0; k < npk; k++) begin
        len = (mode == 1) ? 1 : $urandom_range(1, 4);
        for (int j = 0; j < len; j++)
          pq[p].push_back({(j == len-1), 32'($urandom)});
      end
      cp[p] = pq[p];
    end
    expq.delete();
    rr = 0;
    done = 1'b0;
    while (!done) begin
      found = -1;
      for (int k = 0; k < N; k++)
        if (found < 0 && cp[(rr+k)%N].size() > 0) found = (rr+k)%N;
      if (found < 0) begin
        done = 1'b1;
      end else begin
        do begin
          b = cp[found].pop_front();
          expq.push_back({2'(found), b[DW], b[DW-1:0]});
        end while (!b[DW]);
        rr = (found + 1) % N;
      end
    end
    total = expq.size();
    got = 0;
    cycles = 0;
    bubbles = 0;
    started = 1'b0;
    while (got < total && cycles < 4000) begin
      for (int p = 0; p < N; p++) begin
        in_valid[p] = (pq[p].size() > 0);
        b = (pq[p].size() > 0) ? pq[p][0] : '0;
        in_data[p*DW +: DW] = b[DW-1:0];
        in_last[p] = b[DW];
      end
      out_ready = ($urandom_range(0, 99) < ready_pct);
      @(negedge clk);
      hs = in_valid & in_ready;
      checks++;
      if ($countones(in_ready) > 1 ||
          (out_valid && !out_ready && in_ready !== '0)) begin
        errors++;
        $display("FAIL %s_ready: in_ready=%b ov=%b or=%b",
                 tag, in_ready, out_valid, out_ready);
      end
      if (started && !out_valid) bubbles++;
      if (out_valid) started = 1'b1;
      if (out_valid && out_ready) begin
        e = expq.pop_front();
        got++;
        checks++;
        if (out_src !== e.src || out_data !== e.data ||
            out_last !== e.last) begin
          errors++;
          $display("FAIL %s_beat%0d: got s=%0d d=%h l=%b want s=%0d d=%h l=%b",
                   tag, got-1, out_src, out_data, out_last,
                   e.src, e.data, e.last);
        end
      end
      for (int p = 0; p < N; p++)
        if (hs[p]) void'(pq[p].pop_front());
      @(posedge clk);
      #1;
      cycles++;
    end
    checks++;
    if (got != total) begin
      errors++;
      $display("FAIL %s_timeout: got %0d beats want %0d", tag, got, total);
    end
    if (no_bubble) begin
      checks++;
      if (bubbles != 0) begin
        errors++;
        $display("FAIL %s_bubbles: got %0d want 0", tag, bubbles);
      end
    end
    in_valid  = '0;
    out_ready = 1'b0;
  endtask

  task automatic test_fairness();
    run_stream(1, 100, 1'b1, "fair");
  endtask

  task automatic test_lock();
    do_reset();
    out_ready = 1'b1;
    in_valid = 4'b0001;
    in_data[0 +: DW] = 32'h100;
    in_last = 4'b0001;
    @(negedge clk);
    checks++;
    if (in_ready !== 4'b0001) begin
      errors++;
      $display("FAIL lock_pre: in_ready=%b want 0001", in_ready);
    end
    @(posedge clk);
    #1;
    in_data[0 +: DW] = 32'h200;
    for (int k = 0; k < 4; k++) begin
      in_valid = 4'b0011;
      in_data[DW +: DW] = 32'h1000 + k;
      in_last[1] = (k == 3);
      @(negedge clk);
      checks++;
      if (in_ready !== 4'b0010) begin
        errors++;
        $display("FAIL lock_beat%0d: in_ready=%b want 0010", k, in_ready);
      end
      @(posedge clk);
      #1;
      if (k < 3) begin
        in_valid = 4'b0001;
        @(negedge clk);
        checks++;
        if (in_ready !== 4'b0010) begin
          errors++;
          $display("FAIL lock_gap%0d: in_ready=%b want 0010", k, in_ready);
        end
        @(posedge clk);
        #1;
      end
    end
    in_valid = 4'b1001;
    in_last  = 4'b1001;
    @(negedge clk);
    checks++;
    if (in_ready !== 4'b1000) begin
      errors++;
      $display("FAIL lock_next: in_ready=%b want 1000", in_ready);
    end
    in_valid = '0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    in_valid = 4'b0001;
    in_data[0 +: DW] = 32'hD0D0_0000;
    in_last = 4'b0011;
    @(negedge clk);
    checks++;
    if (in_ready !== 4'b0001) begin
      errors++;
      $display("FAIL bp_load: in_ready=%b want 0001", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 4'b0010;
    in_data[DW +: DW] = 32'hD1D1_1111;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'hD0D0_0000 ||
          out_src !== 2'd0 || out_last !== 1'b1 || in_ready !== '0) begin
        errors++;
        $display("FAIL bp_hold%0d: v=%b d=%h s=%0d l=%b rdy=%b",
                 c, out_valid, out_data, out_src, out_last, in_ready);
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 4'b0010) begin
      errors++;
      $display("FAIL bp_release: in_ready=%b want 0010", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = '0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hD1D1_1111 ||
        out_src !== 2'd1) begin
      errors++;
      $display("FAIL bp_next: v=%b d=%h s=%0d want 1 d1d11111 1",
               out_valid, out_data, out_src);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b1;
    in_last = '0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 4'b1000;
      in_data[3*DW +: DW] = 32'h300 + k;
      if (k < 2) begin
        @(posedge clk);
        #1;
      end
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0) begin
      errors++;
      $display("FAIL rstmid_async: v=%b d=%h want 0 0", out_valid, out_data);
    end
    in_valid = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 4'b1001;
    in_last  = 4'b1001;
    @(negedge clk);
    checks++;
    if (in_ready !== 4'b0001) begin
      errors++;
      $display("FAIL rstmid_grant: in_ready=%b want 0001", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = '0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_src !== 2'd0) begin
      errors++;
      $display("FAIL rstmid_src: v=%b s=%0d want 1 0", out_valid, out_src);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_np2();
    do_reset();
    v3  = 3'b111;
    l3  = 3'b111;
    d3  = {32'h32, 32'h31, 32'h30};
    or3 = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c > 0) begin
        checks++;
        if (ov3 !== 1'b1 || os3 !== 2'((c-1) % 3) ||
            od3 !== 32'h30 + 32'((c-1) % 3)) begin
          errors++;
          $display("FAIL np2_beat%0d: v=%b s=%0d d=%h want 1 %0d",
                   c-1, ov3, os3, od3, (c-1) % 3);
        end
      end
      @(posedge clk);
      #1;
    end
    v3 = '0;
  endtask

  initial begin
    test_reset();
    test_single_source();
    test_fairness();
    test_lock();
    test_backpressure();
    test_reset_mid();
    test_np2();
    run_stream(0, 70, 1'b0, "rand70");
    run_stream(0, 40, 1'b0, "rand40");
    run_stream(0, 100, 1'b0, "rand100");
    run_stream(0, 85, 1'b0, "rand85");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
